// File: rtl/me_block_sched.sv
// me_block_sched: walks a frame's 8x8 blocks in raster order, streams 8 current rows and 23 window rows into core, and returns per-block SAD/MV.
// Latency: a row reaches core one cycle after rd_valid (a zero row one cycle after it is decided); res_valid rises one cycle after core_sad_en.
// Backpressure: rd_req and its address hold until rd_gnt with one read outstanding; res_valid holds fields until res_ready and no reads start meanwhile.
// Optional feature ME_SCHED_TIMEOUT_EN: bounds the wait for core_sad_en to TIMEOUT cycles and flags the result with res_err.
module me_block_sched #(
    parameter int BLK_COLS = 480,
    parameter int BLK_ROWS = 270,
    parameter int TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         rd_req,
    input  logic         rd_gnt,
    output logic         rd_sel,
    output logic [11:0]  rd_row,
    output logic [8:0]   rd_col,
    input  logic         rd_valid,
    input  logic [183:0] rd_data,
    output logic         core_load,
    output logic         core_phase,
    output logic [63:0]  core_crt_row,
    output logic [183:0] core_pre_row,
    input  logic         core_sad_en,
    input  logic [13:0]  core_sad_min,
    input  logic [3:0]   core_mv_x,
    input  logic [3:0]   core_mv_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [8:0]   res_blk_x,
    output logic [8:0]   res_blk_y,
    output logic [13:0]  res_sad,
    output logic [3:0]   res_mv_x,
    output logic [3:0]   res_mv_y,
    output logic         res_err
);
    typedef enum logic [2:0] {IDLE, CRT, PRE, WAIT, OUT} state_t;

    localparam logic signed [12:0] LAST_ROW = 13'(BLK_ROWS * 8 - 1);

    state_t state, state_nxt;
    logic [8:0] bx, by;
    logic [4:0] r;          // row index within the current phase
    logic       outst;      // a granted read is waiting for rd_valid
    logic signed [12:0] pre_tgt;
    logic pre_in, got_data, row_done, crt_last, pre_last, accept, last_blk, expire;

    // Window rows start 7 above the block; rows outside the frame become zero loads.
    assign pre_tgt  = $signed({1'b0, by, 3'b000}) - 13'sd7 + $signed({8'd0, r});
    assign pre_in   = (pre_tgt >= 13'sd0) && (pre_tgt <= LAST_ROW);
    assign got_data = rd_valid && outst;
    assign row_done = got_data || (state == PRE && !outst && !pre_in);
    assign crt_last = (state == CRT) && got_data && (r == 5'd7);
    assign pre_last = (state == PRE) && row_done && (r == 5'd22);
    assign accept   = (state == OUT) && res_ready;
    assign last_blk = (bx == 9'(BLK_COLS - 1)) && (by == 9'(BLK_ROWS - 1));

    assign rd_req    = !outst && ((state == CRT) || (state == PRE && pre_in));
    assign rd_sel    = (state == PRE);
    assign rd_row    = (state == PRE) ? pre_tgt[11:0] : ({by, 3'b000} + 12'(r));
    assign rd_col    = bx;
    assign busy      = (state != IDLE) || done;
    assign res_valid = (state == OUT);
    assign res_blk_x = bx;
    assign res_blk_y = by;

`ifdef ME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;

    assign expire = (wcnt == TW'(TIMEOUT - 1));

    // Count cycles spent in WAIT and mark results that gave up on core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= '0;
            res_err <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (state == WAIT && core_sad_en)
                res_err <= 1'b0;
            else if (state == WAIT && expire)
                res_err <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign res_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: fixed row order per block, then wait for core, then hand off.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CRT;
            CRT:     if (crt_last) state_nxt = PRE;
            PRE:     if (pre_last) state_nxt = WAIT;
            WAIT:    if (core_sad_en || expire) state_nxt = OUT;
            OUT:     if (accept) state_nxt = last_blk ? IDLE : CRT;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: read tracking, row counter, core loads, result capture, block walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx           <= '0;
            by           <= '0;
            r            <= '0;
            outst        <= 1'b0;
            done         <= 1'b0;
            core_load    <= 1'b0;
            core_phase   <= 1'b0;
            core_crt_row <= '0;
            core_pre_row <= '0;
            res_sad      <= '0;
            res_mv_x     <= '0;
            res_mv_y     <= '0;
        end else begin
            core_load <= 1'b0;
            done      <= accept && last_blk;

            if (rd_req && rd_gnt)
                outst <= 1'b1;
            else if (got_data)
                outst <= 1'b0;

            if (state == IDLE && start) begin
                bx <= '0;
                by <= '0;
                r  <= '0;
            end

            if (state == CRT && got_data) begin
                core_load    <= 1'b1;
                core_phase   <= 1'b0;
                core_crt_row <= rd_data[63:0];
                r            <= (r == 5'd7) ? 5'd0 : r + 5'd1;
            end

            if (state == PRE && row_done) begin
                core_load    <= 1'b1;
                core_phase   <= 1'b1;
                core_pre_row <= got_data ? rd_data : '0;
                r            <= (r == 5'd22) ? 5'd0 : r + 5'd1;
            end

            if (state == WAIT && core_sad_en) begin
                res_sad  <= core_sad_min;
                res_mv_x <= core_mv_x;
                res_mv_y <= core_mv_y;
            end else if (state == WAIT && expire) begin
                res_sad  <= 14'h3FFF;
                res_mv_x <= '0;
                res_mv_y <= '0;
            end

            if (accept) begin
                if (bx == 9'(BLK_COLS - 1)) begin
                    bx <= '0;
                    by <= last_blk ? 9'd0 : by + 9'd1;
                end else begin
                    bx <= bx + 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_me_block_sched.sv
`timescale 1ns/1ps
module tb_me_block_sched;
    localparam int BC = 2;
    localparam int BR = 2;
    localparam int TO = 10;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic         busy, done, rd_req, rd_sel, rd_valid, rd_gnt;
    logic [11:0]  rd_row;
    logic [8:0]   rd_col;
    logic [183:0] rd_data;
    logic         core_load, core_phase, core_sad_en;
    logic [63:0]  core_crt_row;
    logic [183:0] core_pre_row;
    logic [13:0]  core_sad_min;
    logic [3:0]   core_mv_x, core_mv_y;
    logic         res_valid, res_ready, res_err;
    logic [8:0]   res_blk_x, res_blk_y;
    logic [13:0]  res_sad;
    logic [3:0]   res_mv_x, res_mv_y;

    me_block_sched #(.BLK_COLS(BC), .BLK_ROWS(BR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_sel(rd_sel), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .core_load(core_load), .core_phase(core_phase), .core_crt_row(core_crt_row),
        .core_pre_row(core_pre_row), .core_sad_en(core_sad_en), .core_sad_min(core_sad_min),
        .core_mv_x(core_mv_x), .core_mv_y(core_mv_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_blk_x(res_blk_x), .res_blk_y(res_blk_y),
        .res_sad(res_sad), .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_err(res_err)
    );

    int total = 0, bad = 0, cyc = 0;
    // block tracker shared by the models
    int cur_bx = 0, cur_by = 0, rd_idx = 0, ld_idx = 0, blk_t0 = 0;
    bit got_first = 0;
    int exp_req_cyc = -1, exp_rv_cyc = -1, exp_done_cyc = -1;
    int done_cnt = 0, res_cnt = 0, hold_left = 0;
    int blk00_pre = 0, blk00_zero = 0, bot_zero = 0;
    bit rnd_mode = 0, spur = 0, silent = 0;
    logic [22:0] exp_res_q[$];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    task automatic check_eq(string tag, logic [183:0] obs, logic [183:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [183:0] mdat(bit sel, int row, int col);
        logic [31:0] h;
        h = 32'(row * 64 + col * 2 + int'(sel) + 1) * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return {h[23:0], {5{h ^ 32'hA5A50F0F}}};
    endfunction
    function automatic int lo_row(int by);
        return (by * 8 - 7 < 0) ? 0 : by * 8 - 7;
    endfunction
    function automatic int hi_row(int by);
        return (by * 8 + 15 > BR * 8 - 1) ? BR * 8 - 1 : by * 8 + 15;
    endfunction
    function automatic int nreads(int by);
        return 8 + hi_row(by) - lo_row(by) + 1;
    endfunction
    function automatic logic [21:0] exp_addr(int bx, int by, int j);
        int row;
        bit sel;
        if (j < 8) begin sel = 1'b0; row = by * 8 + j; end
        else       begin sel = 1'b1; row = lo_row(by) + j - 8; end
        return {sel, 12'(row), 9'(bx)};
    endfunction

    // Frame-buffer model: random grants, 1..5 cycle latency, stray rd_valid pulses.
    initial begin : mem_model
        bit pend = 0, old_pend;
        int lat_left = 0;
        logic [21:0] p_addr = '0;
        logic p_req = 1'b0, p_gnt = 1'b0;
        rd_valid = 1'b0; rd_gnt = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; p_req = 1'b0; rd_valid = 1'b0; rd_gnt = 1'b0;
            end else begin
                if (p_req && !p_gnt) begin
                    check_eq("rd_req_held", rd_req, 1'b1);
                    check_eq("rd_addr_stable", {rd_sel, rd_row, rd_col}, p_addr);
                end
                if (res_valid) check_eq("no_req_in_out", rd_req, 1'b0);
                old_pend = pend;
                rd_valid = 1'b0;
                rd_data = ~mdat(1'b1, 4000 + int'($urandom_range(0, 99)), 7);
                if (pend) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        rd_valid = 1'b1;
                        rd_data = mdat(p_addr[21], int'(p_addr[20:9]), int'(p_addr[8:0]));
                        pend = 0;
                    end
                end else if (rnd_mode && $urandom_range(0, 5) == 0) begin
                    rd_valid = 1'b1;
                end
                if (rd_req && !got_first) begin
                    got_first = 1;
                    blk_t0 = cyc;
                    check_eq("req_after_entry", cyc, exp_req_cyc);
                end
                rd_gnt = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rd_req && rd_gnt) begin
                    check_eq("one_outstanding", old_pend, 1'b0);
                    check_eq("rd_in_budget", rd_idx < nreads(cur_by), 1'b1);
                    check_eq("rd_addr", {rd_sel, rd_row, rd_col}, exp_addr(cur_bx, cur_by, rd_idx));
                    rd_idx++;
                    pend = 1;
                    lat_left = rnd_mode ? int'($urandom_range(1, 5)) : 1;
                end
                p_req = rd_req;
                p_gnt = rd_gnt;
                p_addr = {rd_sel, rd_row, rd_col};
            end
        end
    end

    // Core model: checks every row load against the block's expected rows, answers 3 cycles after the 31st.
    initial begin : core_model
        int cd = 0, k, nr, row;
        logic [183:0] d;
        core_sad_en = 1'b0; core_sad_min = '0; core_mv_x = '0; core_mv_y = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cd = 0; core_sad_en = 1'b0;
            end else begin
                core_sad_en = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        core_sad_min = 14'($urandom);
                        core_mv_x = 4'($urandom);
                        core_mv_y = 4'($urandom);
                        core_sad_en = 1'b1;
                        exp_res_q.push_back({1'b0, core_sad_min, core_mv_x, core_mv_y});
                        exp_rv_cyc = cyc + 1;
                    end
                end
                if (core_load) begin
                    k = ld_idx;
                    check_eq("load_count", k < 31, 1'b1);
                    check_eq("load_phase", core_phase, k >= 8);
                    if (k < 8) begin
                        d = mdat(1'b0, cur_by * 8 + k, cur_bx);
                        check_eq("crt_row", core_crt_row, {120'd0, d[63:0]});
                    end else begin
                        row = cur_by * 8 - 7 + (k - 8);
                        d = (row >= 0 && row <= BR * 8 - 1) ? mdat(1'b1, row, cur_bx) : '0;
                        check_eq("pre_row", core_pre_row, d);
                        if (core_pre_row == '0 && cur_bx == 0 && cur_by == 0 && k < 15) blk00_zero++;
                        if (core_pre_row == '0 && cur_by == BR - 1 && k >= 23) bot_zero++;
                    end
                    ld_idx++;
                    if (ld_idx == 31) begin
                        nr = nreads(cur_by);
                        if (!rnd_mode) check_eq("block_cycles", cyc - blk_t0, 2 * nr + (31 - nr));
                        if (silent) begin
                            exp_res_q.push_back({1'b1, 14'h3FFF, 4'd0, 4'd0});
                            exp_rv_cyc = cyc + TO;
                        end else begin
                            cd = 3;
                        end
                    end
                end else if (spur && cd == 0 && !core_sad_en && ld_idx >= 1 && ld_idx <= 29
                             && $urandom_range(0, 7) == 0) begin
                    core_sad_min = 14'($urandom);
                    core_mv_x = 4'($urandom);
                    core_mv_y = 4'($urandom);
                    core_sad_en = 1'b1;
                end
            end
        end
    end

    // Result sink: checks fields and ordering, drives res_ready, walks the expected block raster.
    initial begin : res_model
        bit prev_rv = 0, rdy;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rv = 0; res_ready = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    check_eq("done_timing", cyc, exp_done_cyc);
                end
                if (res_valid) begin
                    if (!prev_rv) check_eq("res_valid_timing", cyc, exp_rv_cyc);
                    check_eq("res_expected", exp_res_q.size() != 0, 1'b1);
                    if (exp_res_q.size() != 0)
                        check_eq("res_fields", {res_err, res_sad, res_mv_x, res_mv_y}, exp_res_q[0]);
                    check_eq("res_blk", {res_blk_x, res_blk_y}, {9'(cur_bx), 9'(cur_by)});
                    if (hold_left > 0) begin hold_left--; rdy = 0; end
                    else rdy = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                    res_ready = rdy;
                    if (rdy) begin
                        check_eq("blk_reads", rd_idx, nreads(cur_by));
                        check_eq("blk_loads", ld_idx, 31);
                        if (cur_bx == 0 && cur_by == 0) blk00_pre = rd_idx - 8;
                        if (exp_res_q.size() != 0) void'(exp_res_q.pop_front());
                        res_cnt++;
                        if (cur_bx == BC - 1 && cur_by == BR - 1) begin
                            exp_done_cyc = cyc + 1;
                            cur_bx = 0; cur_by = 0;
                        end else begin
                            exp_req_cyc = cyc + 1;
                            if (cur_bx == BC - 1) begin cur_bx = 0; cur_by++; end
                            else cur_bx++;
                        end
                        rd_idx = 0; ld_idx = 0; got_first = 0;
                    end
                end else begin
                    res_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                prev_rv = res_valid;
            end
        end
    end

    task automatic check_idle_outputs(string tag);
        check_eq({tag, "_ctl"}, {busy, done, rd_req, rd_sel, rd_row, rd_col, core_load, core_phase, res_valid, res_err}, '0);
        check_eq({tag, "_res"}, {res_blk_x, res_blk_y, res_sad, res_mv_x, res_mv_y}, '0);
        check_eq({tag, "_crt"}, core_crt_row, '0);
        check_eq({tag, "_pre"}, core_pre_row, '0);
    endtask

    task automatic run_frame(string tag, bit poke);
        int n0, d0, budget;
        n0 = res_cnt; d0 = done_cnt;
        blk00_zero = 0; bot_zero = 0;
        exp_req_cyc = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy_after_start"}, busy, 1'b1);
        budget = 0;
        while (!done && budget < 20000) begin
            @(negedge clk);
            budget++;
            start = (poke && budget == 100) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, done, 1'b1);
        check_eq({tag, "_busy_at_done"}, busy, 1'b1);
        @(negedge clk);
        check_eq({tag, "_busy_fell"}, busy, 1'b0);
        check_eq({tag, "_done_once"}, done_cnt - d0, 1);
        check_eq({tag, "_results"}, res_cnt - n0, BC * BR);
        check_eq({tag, "_blk00_pre_reads"}, blk00_pre, 16);
        check_eq({tag, "_blk00_zero_pre"}, blk00_zero, 7);
        check_eq({tag, "_bottom_zero_pre"}, bot_zero, 8 * BC);
    endtask

    initial begin : main
        int budget;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle");

        // deterministic frame: grant tied high, 1-cycle memory
        rnd_mode = 0; spur = 0;
        run_frame("det", 0);

        // stalls, latency, stray pulses, a 20-cycle result hold, a start poke mid-frame
        rnd_mode = 1; spur = 1; hold_left = 20;
        run_frame("rnd", 1);

        // reset in the middle of PRE
        exp_req_cyc = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (ld_idx < 12 && budget < 5000) begin @(negedge clk); budget++; end
        check_eq("mid_pre_reached", ld_idx >= 12, 1'b1);
        rst = 1'b1;
        cur_bx = 0; cur_by = 0; rd_idx = 0; ld_idx = 0; got_first = 0;
        exp_res_q.delete();
        hold_left = 0;
        #1;
        check_idle_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rnd_mode = 0; spur = 0;
        @(negedge clk);
        run_frame("restart", 0);

`ifdef ME_SCHED_TIMEOUT_EN
        silent = 1;
        run_frame("timeout", 0);
        silent = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/me_block_sched.md
# me_block_sched

Block scheduler for the motion-estimation `core`. It walks a frame's 8x8 blocks in raster order and, for each block, fetches 8 current-frame rows of 64 bits and 23 previous-frame search-window rows of 184 bits. It streams those rows into `core`, captures `sad_min` and the motion vector when `sad_en` fires, and hands each per-block result downstream over a valid/ready port. It sits between the frame-buffer read port and `core`.

## Interface
Parameters:
- `BLK_COLS`, 480: blocks per row (3840/8).
- `BLK_ROWS`, 270: block rows per frame (2160/8).
- `TIMEOUT`, 255: maximum cycles to wait for `sad_en` (used only with the timeout feature).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last result is accepted.
- `rd_req` out 1: read request, held until granted.
- `rd_gnt` in 1: read grant.
- `rd_sel` out 1: 0 = current frame (64-bit row), 1 = previous frame (184-bit window row).
- `rd_row` out 12: pixel row.
- `rd_col` out 9: block column.
- `rd_valid` in 1: read data valid.
- `rd_data` in 184: read data; a current-frame row is in bits [63:0].
- `core_load` out 1: row strobe to `core`.
- `core_phase` out 1: 0 = `crt` row, 1 = `pre` row.
- `core_crt_row` out 64: current-frame row to `core`.
- `core_pre_row` out 184: previous-frame window row to `core`.
- `core_sad_en` in 1: result valid from `core`.
- `core_sad_min` in 14: minimum SAD from `core`.
- `core_mv_x` in 4, `core_mv_y` in 4: motion vector from `core`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_blk_x` out 9, `res_blk_y` out 9: block coordinates of the result.
- `res_sad` out 14: result SAD.
- `res_mv_x` out 4, `res_mv_y` out 4: result motion vector.
- `res_err` out 1: result flagged as timed out.

## Operation
- FSM states: IDLE, CRT, PRE, WAIT, OUT.
- Reset or `start` clears `bx` and `by` to 0.
- IDLE -> CRT on `start`.
- CRT: issues 8 reads with `rd_sel`=0, `rd_row`=`by`*8+r (r = 0..7), `rd_col`=`bx`.
  - Each `rd_valid` gives one `core_load` with `core_phase`=0 and `core_crt_row`=`rd_data[63:0]`.
- PRE: for r = 0..22, the target row is `by`*8-7+r, computed as a signed 13-bit value.
  - In range [0, `BLK_ROWS`*8-1]: read with `rd_sel`=1.
  - Out of range: no read is issued; one `core_load` with `core_pre_row`=0 is produced in a single cycle.
- Row order is fixed: exactly 8 phase-0 loads, then exactly 23 phase-1 loads, per block.
- Read handshake:
  - At most one read outstanding.
  - `rd_req` and its address stay stable until the cycle `rd_gnt`=1.
  - `rd_valid` arrives at least 1 cycle after the grant.
  - `rd_valid` while nothing is outstanding is ignored.
- WAIT: entered after the 23rd pre load. On `core_sad_en`, capture SAD and MV and go to OUT.
  - A `core_sad_en` in any other state is ignored.
- OUT: `res_valid`=1 with all result fields stable until `res_ready`.
  - On accept, `bx` increments. When `bx` wraps from `BLK_COLS`-1 to 0, `by` increments.
  - After block (`BLK_COLS`-1, `BLK_ROWS`-1) is accepted: `done` pulses and the FSM returns to IDLE.
  - Otherwise the FSM goes to CRT.
- Reset values: all outputs 0; FSM in IDLE.
- An asynchronous reset mid-frame abandons any outstanding read and any result.

## Timing
- `core_load` fires in the cycle after the `rd_valid` cycle (registered). For a zero row it fires in the cycle after the row is decided.
- With `rd_gnt` tied to 1 and 1-cycle read latency, each fetched row costs 2 cycles and each zero row costs 1.
  - An interior block takes 62 cycles from entering CRT to the last pre load.
- `res_valid` rises the cycle after `core_sad_en`.
- Accepting a result (`res_valid`&`res_ready`) and entering the next block's CRT happen in the same edge. `rd_req` for the next block asserts the following cycle.
- `busy` is 1 from the cycle after `start` through the `done` cycle inclusive.

## Configuration
- `ME_SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles. If `TIMEOUT` cycles elapse without `core_sad_en`, go to OUT with `res_sad`=14'h3FFF, `res_mv_x`=0, `res_mv_y`=0, `res_err`=1.
  - `core_sad_en` arriving on the same cycle as expiry wins, giving a normal result.
- `ME_SCHED_TIMEOUT_EN` undefined: WAIT waits indefinitely, and `res_err` is constant 0.

## Test plan
- `BLK_COLS`=2, `BLK_ROWS`=2, `start`, `rd_gnt`=1, 1-cycle memory, `core` model returning `sad_en` 3 cycles after the 23rd load -> 4 results in order (0,0),(1,0),(0,1),(1,1); `done` pulses once; `busy` falls after it.
- Block (0,0) -> PRE issues only 16 reads, `rd_row` 0..15. The first 7 `core_pre_row` loads are all zero.
- Block (x, `BLK_ROWS`-1) -> PRE rows beyond `BLK_ROWS`*8-1 are zeroed with no read; the last 8 loads are zero.
- Random `rd_gnt` stalls plus `rd_valid` latency of 1-5 cycles -> `rd_req` and address stable until granted; load order unchanged; never two reads outstanding.
- `res_ready` held low for 20 cycles -> result fields stable, no new `rd_req`. Separately, `rst` pulsed mid-PRE -> all outputs 0 and IDLE; the next `start` restarts from (0,0).
- With `ME_SCHED_TIMEOUT_EN` and `TIMEOUT`=10, `core` silent -> result after 10 WAIT cycles with `res_sad`=3FFF, `res_err`=1.
